snake_dir_ctrl: RTL and testbench

SNAKE_DIR_CTRL -- requirements
Module: snake_dir_ctrl

---
 rtl/snake_dir_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_snake_dir_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: turns debounced key levels and a game-step strobe into a
// committed snake direction, a one-cycle move enable and a pause flag.
// Turns pressed between steps wait in a small pending queue.
// Build option: define SNAKE_DIR_QUEUE_EN for a 2-entry turn FIFO; the
// default build keeps a single pending slot that each new turn overwrites.
module snake_dir_ctrl #(
    parameter logic KEY_PRESSED = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_up,
    input  logic       key_right,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_pause,
    input  logic       tick,
    input  logic       game_over,
    output logic [1:0] dir,
    output logic       dir_chg,
    output logic       step,
    output logic       paused,
    output logic [1:0] q_cnt
);

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_e;

    localparam logic [4:0] IDLE_LVL = {5{~KEY_PRESSED}};

    // Bit order: {pause, left, down, right, up}
    logic [4:0] key_lvl;
    logic [4:0] prev_q;
    logic [4:0] press;

    dir_e dir_q, dir_d;
    logic dir_chg_q, dir_chg_d;
    logic step_q, step_d;
    logic paused_q, paused_d;

    logic step_go;
    logic cand_vld;
    dir_e cand;
    dir_e ref_dir;
    dir_e head;
    logic turn_ok;
    logic pop;

    assign key_lvl = {key_pause, key_left, key_down, key_right, key_up};

    // Press = level now at KEY_PRESSED while the previous level was not
    assign press   = game_over ? '0 : ((key_lvl ^ IDLE_LVL) & ~(prev_q ^ IDLE_LVL));
    assign step_go = tick && !paused_q && !game_over;

    // Priority resolve of simultaneous direction presses: up > right > down > left
    always_comb begin
        cand_vld = 1'b0;
        cand     = DIR_UP;
        if (press[0]) begin
            cand_vld = 1'b1;
            cand     = DIR_UP;
        end else if (press[1]) begin
            cand_vld = 1'b1;
            cand     = DIR_RIGHT;
        end else if (press[2]) begin
            cand_vld = 1'b1;
            cand     = DIR_DOWN;
        end else if (press[3]) begin
            cand_vld = 1'b1;
            cand     = DIR_LEFT;
        end
        if (paused_q) begin
            cand_vld = 1'b0;
        end
    end

    // A turn is refused if it repeats or reverses the reference direction
    assign turn_ok = cand_vld && (cand != ref_dir) && (cand != dir_e'(ref_dir ^ 2'b10));

`ifdef SNAKE_DIR_QUEUE_EN

    dir_e q0_q, q0_d;
    dir_e q1_q, q1_d;
    logic [1:0] cnt_q, cnt_d;

    assign ref_dir = (cnt_q == 2'd0) ? dir_q : ((cnt_q == 2'd2) ? q1_q : q0_q);
    assign head    = q0_q;
    assign pop     = step_go && (cnt_q != 2'd0);
    assign q_cnt   = cnt_q;

    // FIFO update: pop first so a full queue can still take a push in the same cycle
    always_comb begin
        q0_d  = q0_q;
        q1_d  = q1_q;
        cnt_d = cnt_q;
        if (pop) begin
            q0_d  = q1_q;
            cnt_d = cnt_q - 2'd1;
        end
        if (turn_ok && (cnt_d != 2'd2)) begin
            if (cnt_d == 2'd0) begin
                q0_d = cand;
            end else begin
                q1_d = cand;
            end
            cnt_d = cnt_d + 2'd1;
        end
        if (game_over) begin
            cnt_d = '0;
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (rst) begin
            q0_q  <= DIR_UP;
            q1_q  <= DIR_UP;
            cnt_q <= '0;
        end else begin
            q0_q  <= q0_d;
            q1_q  <= q1_d;
            cnt_q <= cnt_d;
        end
    end

`else

    dir_e slot_q, slot_d;
    logic pend_q, pend_d;

    assign ref_dir = dir_q;
    assign head    = slot_q;
    assign pop     = step_go && pend_q;
    assign q_cnt   = {1'b0, pend_q};

    // Single slot: a new valid turn replaces whatever is pending
    always_comb begin
        slot_d = slot_q;
        pend_d = pend_q;
        if (pop) begin
            pend_d = 1'b0;
        end
        if (turn_ok) begin
            slot_d = cand;
            pend_d = 1'b1;
        end
        if (game_over) begin
            pend_d = 1'b0;
        end
    end

    // Pending slot storage
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= DIR_UP;
            pend_q <= 1'b0;
        end else begin
            slot_q <= slot_d;
            pend_q <= pend_d;
        end
    end

`endif

    // Direction commit, step strobe and pause toggle
    always_comb begin
        dir_d     = dir_q;
        dir_chg_d = 1'b0;
        step_d    = step_go;
        paused_d  = paused_q ^ press[4];
        if (pop) begin
            dir_d     = head;
            dir_chg_d = (head != dir_q);
        end
        if (game_over) begin
            paused_d = 1'b0;
        end
    end

    // Output and previous-level registers
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q    <= IDLE_LVL;
            dir_q     <= DIR_RIGHT;
            dir_chg_q <= 1'b0;
            step_q    <= 1'b0;
            paused_q  <= 1'b0;
        end else begin
            prev_q    <= key_lvl;
            dir_q     <= dir_d;
            dir_chg_q <= dir_chg_d;
            step_q    <= step_d;
            paused_q  <= paused_d;
        end
    end

    assign dir     = dir_q;
    assign dir_chg = dir_chg_q;
    assign step    = step_q;
    assign paused  = paused_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl: directed vector table, then random stimulus
// checked against a queue-based model of the turn rules.
module tb_snake_dir_ctrl;

    localparam logic KP = 1'b1;
`ifdef SNAKE_DIR_QUEUE_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] UP   = 5'b00001;
    localparam logic [4:0] RT   = 5'b00010;
    localparam logic [4:0] DN   = 5'b00100;
    localparam logic [4:0] LF   = 5'b01000;
    localparam logic [4:0] PS   = 5'b10000;

    logic clk = 1'b0;
    logic rst, key_up, key_right, key_down, key_left, key_pause, tick, game_over;
    logic [1:0] dir, q_cnt;
    logic dir_chg, step, paused;

    always #5 clk = ~clk;

    snake_dir_ctrl #(.KEY_PRESSED(KP)) dut (
        .clk(clk), .rst(rst),
        .key_up(key_up), .key_right(key_right), .key_down(key_down), .key_left(key_left),
        .key_pause(key_pause), .tick(tick), .game_over(game_over),
        .dir(dir), .dir_chg(dir_chg), .step(step), .paused(paused), .q_cnt(q_cnt)
    );

    typedef struct {
        logic       r;
        logic [4:0] k;
        logic       t;
        logic       g;
        logic [1:0] e_dir;
        logic       e_chg;
        logic       e_step;
        logic       e_pau;
        logic [1:0] e_q;
    } vec_t;

    vec_t vecs[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [1:0] m_dir;
    logic       m_chg, m_step, m_paused;
    logic [1:0] mq[$];
    logic [4:0] m_prev;

    task automatic add(input logic r, input logic [4:0] k, input logic t, input logic g,
                       input logic [1:0] d, input logic c, input logic s, input logic p,
                       input logic [1:0] q);
        vec_t v;
        v.r = r; v.k = k; v.t = t; v.g = g;
        v.e_dir = d; v.e_chg = c; v.e_step = s; v.e_pau = p; v.e_q = q;
        vecs.push_back(v);
    endtask

    task automatic apply(input logic r, input logic [4:0] k, input logic t, input logic g);
        rst = r;
        {key_pause, key_left, key_down, key_right, key_up} = k;
        tick = t;
        game_over = g;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [1:0] d, input logic c,
                         input logic s, input logic p, input logic [1:0] q);
        n_checks++;
        if ({dir, dir_chg, step, paused, q_cnt} !== {d, c, s, p, q}) begin
            n_fail++;
            $display("FAIL %s[%0d]: got dir=%b chg=%b step=%b paused=%b q_cnt=%0d, want dir=%b chg=%b step=%b paused=%b q_cnt=%0d",
                     name, idx, dir, dir_chg, step, paused, q_cnt, d, c, s, p, q);
        end
    endtask

    // One clock of the game rules: press edges, priority, turn legality, queue, pause
    function automatic void model_step(input logic r, input logic [4:0] k, input logic t, input logic g);
        logic [4:0] ev;
        logic       have;
        logic [1:0] cand, refd, nd;
        logic       stepnow;
        if (r) begin
            m_dir = 2'b01; m_chg = 1'b0; m_step = 1'b0; m_paused = 1'b0;
            mq.delete();
            m_prev = {5{~KP}};
            return;
        end
        for (int i = 0; i < 5; i++) ev[i] = (k[i] == KP) && (m_prev[i] != KP);
        m_prev = k;
        if (g) begin
            mq.delete(); m_paused = 1'b0; m_step = 1'b0; m_chg = 1'b0;
            return;
        end
        stepnow = t && !m_paused;
        have = 1'b0;
        cand = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (ev[i] && !have) begin
                have = 1'b1;
                cand = 2'(i);
            end
        end
        if (m_paused) have = 1'b0;
        refd = (DEPTH > 1 && mq.size() > 0) ? mq[mq.size()-1] : m_dir;
        m_step = stepnow;
        m_chg  = 1'b0;
        if (stepnow && mq.size() > 0) begin
            nd = mq.pop_front();
            m_chg = (nd != m_dir);
            m_dir = nd;
        end
        if (have && cand != refd && cand != (refd ^ 2'b10)) begin
            if (DEPTH == 1) begin
                mq.delete();
                mq.push_back(cand);
            end else if (mq.size() < DEPTH) begin
                mq.push_back(cand);
            end
        end
        if (ev[4]) m_paused = !m_paused;
    endfunction

    initial begin
        logic [4:0] kl;
        logic       gl, rr, tt;
        rst = 1'b1; key_up = 1'b0; key_right = 1'b0; key_down = 1'b0; key_left = 1'b0;
        key_pause = 1'b0; tick = 1'b0; game_over = 1'b0;

        // Basic turn, rejected turns, pause, game over, reset behaviour
        add(1, NONE, 0, 0, 2'd1, 0, 0, 0, 2'd0);
        add(0, NONE, 0, 0, 2'd1, 0, 0, 0, 2'd0);
        add(0, UP,   0, 0, 2'd1, 0, 0, 0, 2'd1);
        add(0, NONE, 1, 0, 2'd0, 1, 1, 0, 2'd0);
        add(0, NONE, 0, 0, 2'd0, 0, 0, 0, 2'd0);
        add(1, NONE, 0, 0, 2'd1, 0, 0, 0, 2'd0);
        add(0, LF,   0, 0, 2'd1, 0, 0, 0, 2'd0);
        add(0, NONE, 1, 0, 2'd1, 0, 1, 0, 2'd0);
        add(0, NONE, 0, 0, 2'd1, 0, 0, 0, 2'd0);
        add(0, RT,   0, 0, 2'd1, 0, 0, 0, 2'd0);
        add(0, NONE, 0, 0, 2'd1, 0, 0, 0, 2'd0);
        add(0, PS,   0, 0, 2'd1, 0, 0, 1, 2'd0);
        add(0, NONE, 1, 0, 2'd1, 0, 0, 1, 2'd0);
        add(0, DN,   0, 0, 2'd1, 0, 0, 1, 2'd0);
        add(0, NONE, 0, 0, 2'd1, 0, 0, 1, 2'd0);
        add(0, PS,   0, 0, 2'd1, 0, 0, 0, 2'd0);
        add(0, NONE, 1, 0, 2'd1, 0, 1, 0, 2'd0);
        add(0, NONE, 0, 0, 2'd1, 0, 0, 0, 2'd0);
        add(0, UP,   0, 0, 2'd1, 0, 0, 0, 2'd1);
        add(0, NONE, 0, 1, 2'd1, 0, 0, 0, 2'd0);
        add(0, NONE, 1, 1, 2'd1, 0, 0, 0, 2'd0);
        add(0, NONE, 0, 0, 2'd1, 0, 0, 0, 2'd0);
        add(0, PS,   0, 0, 2'd1, 0, 0, 1, 2'd0);
        add(0, NONE, 0, 1, 2'd1, 0, 0, 0, 2'd0);
        add(0, NONE, 0, 0, 2'd1, 0, 0, 0, 2'd0);
        add(1, UP,   0, 0, 2'd1, 0, 0, 0, 2'd0);
        add(0, UP,   0, 0, 2'd1, 0, 0, 0, 2'd1);
        add(0, UP,   0, 0, 2'd1, 0, 0, 0, 2'd1);
        add(0, NONE, 1, 0, 2'd0, 1, 1, 0, 2'd0);
        add(0, LF,   0, 0, 2'd0, 0, 0, 0, 2'd1);
        add(1, NONE, 1, 0, 2'd1, 0, 0, 0, 2'd0);
        add(0, NONE, 0, 0, 2'd1, 0, 0, 0, 2'd0);
`ifdef SNAKE_DIR_QUEUE_EN
        // Two queued turns, push+pop on a full queue, full-queue discard
        add(0, UP,   0, 0, 2'd1, 0, 0, 0, 2'd1);
        add(0, LF,   0, 0, 2'd1, 0, 0, 0, 2'd2);
        add(0, NONE, 1, 0, 2'd0, 1, 1, 0, 2'd1);
        add(0, NONE, 1, 0, 2'd3, 1, 1, 0, 2'd0);
        add(0, NONE, 0, 0, 2'd3, 0, 0, 0, 2'd0);
        add(0, UP,   0, 0, 2'd3, 0, 0, 0, 2'd1);
        add(0, RT,   0, 0, 2'd3, 0, 0, 0, 2'd2);
        add(0, DN,   1, 0, 2'd0, 1, 1, 0, 2'd2);
        add(0, LF,   0, 0, 2'd0, 0, 0, 0, 2'd2);
        add(0, NONE, 1, 0, 2'd1, 1, 1, 0, 2'd1);
        add(0, NONE, 1, 0, 2'd2, 1, 1, 0, 2'd0);
`else
        // Overwrite of the pending slot and push+pop in one cycle
        add(0, UP,   0, 0, 2'd1, 0, 0, 0, 2'd1);
        add(0, DN,   0, 0, 2'd1, 0, 0, 0, 2'd1);
        add(0, NONE, 1, 0, 2'd2, 1, 1, 0, 2'd0);
        add(0, LF,   1, 0, 2'd2, 0, 1, 0, 2'd1);
        add(0, UP,   1, 0, 2'd3, 1, 1, 0, 2'd0);
        add(0, NONE, 0, 0, 2'd3, 0, 0, 0, 2'd0);
        add(0, DN,   0, 0, 2'd3, 0, 0, 0, 2'd1);
        add(0, UP,   1, 0, 2'd2, 1, 1, 0, 2'd1);
        add(0, NONE, 1, 0, 2'd0, 1, 1, 0, 2'd0);
`endif

        foreach (vecs[i]) begin
            apply(vecs[i].r, vecs[i].k, vecs[i].t, vecs[i].g);
            check("vec", i, vecs[i].e_dir, vecs[i].e_chg, vecs[i].e_step, vecs[i].e_pau, vecs[i].e_q);
        end

        // Hand sequence: step strobe lasts one cycle even with tick held off afterwards
        apply(1, NONE, 0, 0);
        apply(0, NONE, 1, 0);
        check("seq_step", 0, 2'd1, 0, 1, 0, 2'd0);
        apply(0, NONE, 0, 0);
        check("seq_step", 1, 2'd1, 0, 0, 0, 2'd0);
        apply(0, DN | UP, 0, 0);
        check("seq_prio", 0, 2'd1, 0, 0, 0, 2'd1);
        apply(0, NONE, 1, 0);
        check("seq_prio", 1, 2'd0, 1, 1, 0, 2'd0);

        // Random stimulus against the model
        kl = NONE; gl = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) kl[b] = ~kl[b];
            if ($urandom_range(0, 19) == 0) kl[4] = ~kl[4];
            if ($urandom_range(0, 39) == 0) gl = ~gl;
            rr = (c == 0) || ($urandom_range(0, 149) == 0);
            tt = ($urandom_range(0, 2) == 0);
            apply(rr, kl, tt, gl);
            model_step(rr, kl, tt, gl);
            check("rand", c, m_dir, m_chg, m_step, m_paused, 2'(mq.size()));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
